// File: rtl/cpu_pkg.sv
// Shared encodings for the ID/EX stage: opcode/funct values, ALU select codes and immediate modes.
package cpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h00;

  localparam logic [2:0] ALU_SEL_ADD  = 3'b000;
  localparam logic [2:0] ALU_SEL_NOOP = 3'b001;
  localparam logic [2:0] ALU_SEL_AND  = 3'b010;
  localparam logic [2:0] ALU_SEL_OR   = 3'b011;
  localparam logic [2:0] ALU_SEL_SLT  = 3'b100;
  localparam logic [2:0] ALU_SEL_SLL  = 3'b101;
  localparam logic [2:0] ALU_SEL_BEQ  = 3'b110;
  localparam logic [2:0] ALU_SEL_BNE  = 3'b111;

  typedef enum logic {IMM_ZEXT = 1'b0, IMM_SEXT = 1'b1} imm_mode_e;

  function automatic logic [31:0] ext_imm16(input logic [15:0] imm, input imm_mode_e mode);
    return (mode == IMM_SEXT) ? {{16{imm[15]}}, imm} : {16'h0000, imm};
  endfunction
endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of opcode/funct into ALU select and per-instruction control bits.
module alu_ctrl_decode
  import cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] sel,
  output imm_mode_e  imm_mode,
  output logic       use_imm,
  output logic       wr_en,
  output logic       wr_rt,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       illegal
);
  always_comb begin
    sel      = ALU_SEL_NOOP;
    imm_mode = IMM_SEXT;
    use_imm  = 1'b0;
    wr_en    = 1'b0;
    wr_rt    = (opcode != OP_RTYPE);
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        wr_en = 1'b1;
        case (funct)
          FN_ADD:  sel = ALU_SEL_ADD;
          FN_AND:  sel = ALU_SEL_AND;
          FN_OR:   sel = ALU_SEL_OR;
          FN_SLT:  sel = ALU_SEL_SLT;
          FN_SLL:  sel = ALU_SEL_SLL;
          default: begin
            illegal = 1'b1;
            wr_en   = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin sel = ALU_SEL_ADD; use_imm = 1'b1; wr_en = 1'b1; end
      OP_ANDI: begin sel = ALU_SEL_AND; use_imm = 1'b1; wr_en = 1'b1; imm_mode = IMM_ZEXT; end
      OP_ORI:  begin sel = ALU_SEL_OR;  use_imm = 1'b1; wr_en = 1'b1; imm_mode = IMM_ZEXT; end
      OP_SLTI: begin sel = ALU_SEL_SLT; use_imm = 1'b1; wr_en = 1'b1; end
      OP_LW:   begin sel = ALU_SEL_ADD; use_imm = 1'b1; wr_en = 1'b1; mem_rd = 1'b1; end
      OP_SW:   begin sel = ALU_SEL_ADD; use_imm = 1'b1; mem_wr = 1'b1; end
      OP_BEQ:  sel = ALU_SEL_BEQ;
      OP_BNE:  sel = ALU_SEL_BNE;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush, operand forwarding and ALU decode.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic [5:0]    id_opcode,
  input  logic [5:0]    id_funct,
  input  logic [RW-1:0] id_rs_addr,
  input  logic [RW-1:0] id_rt_addr,
  input  logic [RW-1:0] id_rd_addr,
  input  logic [DW-1:0] id_rs_val,
  input  logic [DW-1:0] id_rt_val,
  input  logic [15:0]   id_imm16,
  input  logic          exm_wr_en,
  input  logic [RW-1:0] exm_wr_addr,
  input  logic [DW-1:0] exm_wr_data,
  input  logic          mwb_wr_en,
  input  logic [RW-1:0] mwb_wr_addr,
  input  logic [DW-1:0] mwb_wr_data,
  input  logic          ex_ready,
  output logic          ex_valid,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_sel,
  output logic [DW-1:0] ex_store_data,
  output logic          ex_wr_en,
  output logic [RW-1:0] ex_wr_addr,
  output logic          ex_mem_rd,
  output logic          ex_mem_wr,
  output logic          ex_illegal
);
  logic          vld_p1;
  logic [5:0]    opcode_p1, funct_p1;
  logic [RW-1:0] rs_addr_p1, rt_addr_p1, rd_addr_p1;
  logic [DW-1:0] rs_val_p1, rt_val_p1;
  logic [15:0]   imm16_p1;

  logic [2:0]    dec_sel;
  imm_mode_e     dec_imm_mode;
  logic          dec_use_imm, dec_wr_en, dec_wr_rt, dec_mem_rd, dec_mem_wr, dec_illegal;
  logic [DW-1:0] fwd_rs, fwd_rt;

  function automatic logic [DW-1:0] fwd_sel(
    input logic [RW-1:0] src, input logic [DW-1:0] rf_val,
    input logic e_en, input logic [RW-1:0] e_addr, input logic [DW-1:0] e_data,
    input logic m_en, input logic [RW-1:0] m_addr, input logic [DW-1:0] m_data);
    if (src == '0)                  return '0;
    else if (e_en && e_addr == src) return e_data;
    else if (m_en && m_addr == src) return m_data;
    else                            return rf_val;
  endfunction

  assign id_ready = !vld_p1 || ex_ready;

  // ID -> EX boundary: flush wins over capture; an accept with nothing new empties the stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      opcode_p1  <= '0;
      funct_p1   <= '0;
      rs_addr_p1 <= '0;
      rt_addr_p1 <= '0;
      rd_addr_p1 <= '0;
      rs_val_p1  <= '0;
      rt_val_p1  <= '0;
      imm16_p1   <= '0;
    end else begin
      if (flush)                      vld_p1 <= 1'b0;
      else if (id_valid && id_ready)  vld_p1 <= 1'b1;
      else if (ex_ready)              vld_p1 <= 1'b0;
      if (id_valid && id_ready) begin
        opcode_p1  <= id_opcode;
        funct_p1   <= id_funct;
        rs_addr_p1 <= id_rs_addr;
        rt_addr_p1 <= id_rt_addr;
        rd_addr_p1 <= id_rd_addr;
        rs_val_p1  <= id_rs_val;
        rt_val_p1  <= id_rt_val;
        imm16_p1   <= id_imm16;
      end
    end
  end

  alu_ctrl_decode u_dec (
    .opcode   (opcode_p1),
    .funct    (funct_p1),
    .sel      (dec_sel),
    .imm_mode (dec_imm_mode),
    .use_imm  (dec_use_imm),
    .wr_en    (dec_wr_en),
    .wr_rt    (dec_wr_rt),
    .mem_rd   (dec_mem_rd),
    .mem_wr   (dec_mem_wr),
    .illegal  (dec_illegal)
  );

  // Forwarding is re-evaluated every cycle so a stalled instruction sees the latest results
  assign fwd_rs = fwd_sel(rs_addr_p1, rs_val_p1, exm_wr_en, exm_wr_addr, exm_wr_data,
                          mwb_wr_en, mwb_wr_addr, mwb_wr_data);
  assign fwd_rt = fwd_sel(rt_addr_p1, rt_val_p1, exm_wr_en, exm_wr_addr, exm_wr_data,
                          mwb_wr_en, mwb_wr_addr, mwb_wr_data);

  assign alu_a         = (dec_sel == ALU_SEL_SLL) ? fwd_rt : fwd_rs;
  assign alu_b         = dec_use_imm ? ext_imm16(imm16_p1, dec_imm_mode) : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_wr_addr    = dec_wr_rt ? rt_addr_p1 : rd_addr_p1;
  assign ex_valid      = vld_p1;
  assign alu_sel       = vld_p1 ? dec_sel : ALU_SEL_NOOP;
  assign ex_wr_en      = vld_p1 && dec_wr_en && (ex_wr_addr != '0);
  assign ex_mem_rd     = vld_p1 && dec_mem_rd;
  assign ex_mem_wr     = vld_p1 && dec_mem_wr;
  assign ex_illegal    = vld_p1 && dec_illegal;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: behavioural model checked every cycle plus literal expectations.
module tb_id_ex_stage;
  logic        clk, rst_n, flush, id_valid, id_ready;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [31:0] id_rs_val, id_rt_val;
  logic [15:0] id_imm16;
  logic        exm_wr_en, mwb_wr_en;
  logic [4:0]  exm_wr_addr, mwb_wr_addr;
  logic [31:0] exm_wr_data, mwb_wr_data;
  logic        ex_ready, ex_valid;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [2:0]  alu_sel;
  logic        ex_wr_en, ex_mem_rd, ex_mem_wr, ex_illegal;
  logic [4:0]  ex_wr_addr;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_funct(id_funct), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr), .id_rs_val(id_rs_val),
    .id_rt_val(id_rt_val), .id_imm16(id_imm16), .exm_wr_en(exm_wr_en),
    .exm_wr_addr(exm_wr_addr), .exm_wr_data(exm_wr_data), .mwb_wr_en(mwb_wr_en),
    .mwb_wr_addr(mwb_wr_addr), .mwb_wr_data(mwb_wr_data), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .ex_store_data(ex_store_data), .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsv, rtv;
    logic [15:0] imm;
  } ins_t;

  typedef struct {
    logic [2:0]  sel;
    logic        wr, mrd, mwr, ill;
    logic [31:0] a, b, st;
    logic [4:0]  dst;
  } exp_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Register value as seen by the instruction: r0 is zero, newest writer wins
  function automatic logic [31:0] fw(input logic [4:0] ad, input logic [31:0] rf);
    if (ad == 5'd0) return 32'd0;
    if (exm_wr_en && exm_wr_addr == ad) return exm_wr_data;
    if (mwb_wr_en && mwb_wr_addr == ad) return mwb_wr_data;
    return rf;
  endfunction

  function automatic exp_t predict(input ins_t i);
    exp_t e;
    logic [31:0] s, z;
    s = {{16{i.imm[15]}}, i.imm};
    z = {16'h0000, i.imm};
    e.a = fw(i.rs, i.rsv);
    e.b = fw(i.rt, i.rtv);
    e.st = e.b;
    e.sel = 3'd1; e.ill = 1'b1; e.wr = 1'b0; e.mrd = 1'b0; e.mwr = 1'b0;
    e.dst = (i.op == 6'h00) ? i.rd : i.rt;
    if (i.op == 6'h00) begin
      case (i.fn)
        6'h20: begin e.sel = 3'd0; e.ill = 0; e.wr = 1; end
        6'h24: begin e.sel = 3'd2; e.ill = 0; e.wr = 1; end
        6'h25: begin e.sel = 3'd3; e.ill = 0; e.wr = 1; end
        6'h2A: begin e.sel = 3'd4; e.ill = 0; e.wr = 1; end
        6'h00: begin e.sel = 3'd5; e.ill = 0; e.wr = 1; e.a = fw(i.rt, i.rtv); end
        default: ;
      endcase
    end else begin
      case (i.op)
        6'h08: begin e.sel = 3'd0; e.ill = 0; e.wr = 1; e.b = s; end
        6'h0C: begin e.sel = 3'd2; e.ill = 0; e.wr = 1; e.b = z; end
        6'h0D: begin e.sel = 3'd3; e.ill = 0; e.wr = 1; e.b = z; end
        6'h0A: begin e.sel = 3'd4; e.ill = 0; e.wr = 1; e.b = s; end
        6'h23: begin e.sel = 3'd0; e.ill = 0; e.wr = 1; e.b = s; e.mrd = 1; end
        6'h2B: begin e.sel = 3'd0; e.ill = 0; e.b = s; e.mwr = 1; end
        6'h04: begin e.sel = 3'd6; e.ill = 0; end
        6'h05: begin e.sel = 3'd7; e.ill = 0; end
        default: ;
      endcase
    end
    e.wr = e.wr && (e.dst != 5'd0);
    return e;
  endfunction

  // Model state: whether an instruction is held, and which one
  bit   m_vld;
  ins_t m_ins;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_vld = 1'b0;
    else begin
      bit cap;
      cap = id_valid && (!m_vld || ex_ready);
      if (cap) m_ins = {id_opcode, id_funct, id_rs_addr, id_rt_addr, id_rd_addr,
                        id_rs_val, id_rt_val, id_imm16};
      if (flush)         m_vld = 1'b0;
      else if (cap)      m_vld = 1'b1;
      else if (ex_ready) m_vld = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      chk("ex_valid", 32'(ex_valid), 32'(m_vld));
      chk("id_ready", 32'(id_ready), 32'(!m_vld || ex_ready));
      if (m_vld) begin
        e = predict(m_ins);
        chk("m_alu_sel", 32'(alu_sel), 32'(e.sel));
        chk("m_illegal", 32'(ex_illegal), 32'(e.ill));
        chk("m_wr_en", 32'(ex_wr_en), 32'(e.wr));
        chk("m_mem_rd", 32'(ex_mem_rd), 32'(e.mrd));
        chk("m_mem_wr", 32'(ex_mem_wr), 32'(e.mwr));
        chk("m_store", ex_store_data, e.st);
        if (!e.ill) begin
          chk("m_alu_a", alu_a, e.a);
          chk("m_alu_b", alu_b, e.b);
          chk("m_wr_addr", 32'(ex_wr_addr), 32'(e.dst));
        end
      end else begin
        chk("idle_sel", 32'(alu_sel), 32'd1);
        chk("idle_ctl", 32'({ex_wr_en, ex_mem_rd, ex_mem_wr, ex_illegal}), 32'd0);
      end
    end
  end

  function automatic ins_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsv,
                              input logic [31:0] rtv, input logic [15:0] imm);
    return {op, fn, rs, rt, rd, rsv, rtv, imm};
  endfunction

  task automatic drive(input ins_t i);
    {id_opcode, id_funct, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_val, id_rt_val, id_imm16} = i;
    id_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  ins_t tbl[6];

  initial begin
    rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    drive(mk(6'h3F, 6'h3F, 5'd7, 5'd7, 5'd7, 32'hDEAD, 32'hBEEF, 16'h1234));
    id_valid = 1'b0;
    exm_wr_en = 1'b0; exm_wr_addr = '0; exm_wr_data = '0;
    mwb_wr_en = 1'b0; mwb_wr_addr = '0; mwb_wr_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd1);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_store", ex_store_data, 32'd0);
    chk("rst_ctl", 32'({ex_wr_en, ex_mem_rd, ex_mem_wr, ex_illegal, ex_wr_addr}), 32'd0);
    chk("rst_id_ready", 32'(id_ready), 32'd1);
    tick(); rst_n = 1'b1;

    // addi with all-ones immediate
    drive(mk(6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 32'd5, 32'd7, 16'hFFFF));
    tick(); id_valid = 1'b0;
    @(negedge clk);
    chk("addi_a", alu_a, 32'd5);
    chk("addi_b", alu_b, 32'hFFFFFFFF);
    chk("addi_sel", 32'(alu_sel), 32'd0);
    chk("addi_dst", 32'(ex_wr_addr), 32'd2);
    chk("addi_wr", 32'(ex_wr_en), 32'd1);

    // ori zero-extends
    drive(mk(6'h0D, 6'h00, 5'd1, 5'd4, 5'd0, 32'd5, 32'd0, 16'h8000));
    tick(); id_valid = 1'b0;
    @(negedge clk);
    chk("ori_b", alu_b, 32'h00008000);
    chk("ori_sel", 32'(alu_sel), 32'd3);

    // forwarding priority, then held instruction sees MEM/WB only
    #1;
    exm_wr_en = 1'b1; exm_wr_addr = 5'd3; exm_wr_data = 32'hAA;
    mwb_wr_en = 1'b1; mwb_wr_addr = 5'd3; mwb_wr_data = 32'hBB;
    drive(mk(6'h00, 6'h20, 5'd3, 5'd5, 5'd6, 32'h11, 32'h22, 16'h0000));
    tick(); id_valid = 1'b0; ex_ready = 1'b0;
    @(negedge clk);
    chk("fwd_exm", alu_a, 32'hAA);
    chk("fwd_rt_rf", alu_b, 32'h22);
    tick(); exm_wr_en = 1'b0;
    @(negedge clk);
    chk("fwd_mwb", alu_a, 32'hBB);
    chk("fwd_held", 32'(ex_valid), 32'd1);
    #1;
    ex_ready = 1'b1; mwb_wr_en = 1'b0;
    exm_wr_en = 1'b1; exm_wr_addr = 5'd0; exm_wr_data = 32'hCC;
    drive(mk(6'h00, 6'h20, 5'd0, 5'd5, 5'd6, 32'h99, 32'h22, 16'h0000));
    tick(); id_valid = 1'b0;
    @(negedge clk);
    chk("fwd_r0", alu_a, 32'd0);

    // stall: new instruction waits until EX accepts the held one
    #1;
    exm_wr_en = 1'b0; ex_ready = 1'b0;
    drive(mk(6'h00, 6'h24, 5'd1, 5'd2, 5'd7, 32'hF0, 32'h3C, 16'h0000));
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("stall_ready", 32'(id_ready), 32'd0);
      chk("stall_sel", 32'(alu_sel), 32'd0);
      chk("stall_valid", 32'(ex_valid), 32'd1);
    end
    #1; ex_ready = 1'b1; #1;
    chk("stall_release", 32'(id_ready), 32'd1);
    chk("stall_not_yet", 32'(alu_sel), 32'd0);
    tick(); id_valid = 1'b0;
    @(negedge clk);
    chk("stall_new_sel", 32'(alu_sel), 32'd2);
    chk("stall_new_a", alu_a, 32'hF0);
    chk("stall_new_b", alu_b, 32'h3C);
    chk("stall_new_dst", 32'(ex_wr_addr), 32'd7);

    // flush beats capture
    #1;
    drive(mk(6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 32'd1, 32'd0, 16'h0004));
    flush = 1'b1;
    tick(); flush = 1'b0; id_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_sel", 32'(alu_sel), 32'd1);
    chk("flush_mrd", 32'(ex_mem_rd), 32'd0);

    // illegal opcode
    #1;
    drive(mk(6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'h0000));
    tick(); id_valid = 1'b0;
    @(negedge clk);
    chk("ill_flag", 32'(ex_illegal), 32'd1);
    chk("ill_sel", 32'(alu_sel), 32'd1);
    chk("ill_wr", 32'(ex_wr_en), 32'd0);
    chk("ill_valid", 32'(ex_valid), 32'd1);

    // write to r0 is suppressed
    #1;
    drive(mk(6'h08, 6'h00, 5'd1, 5'd0, 5'd0, 32'd1, 32'd0, 16'h0001));
    tick(); id_valid = 1'b0;
    @(negedge clk);
    chk("r0_wr", 32'(ex_wr_en), 32'd0);

    // sw with store data forwarded from MEM/WB
    #1;
    mwb_wr_en = 1'b1; mwb_wr_addr = 5'd9; mwb_wr_data = 32'h5555;
    drive(mk(6'h2B, 6'h00, 5'd1, 5'd9, 5'd0, 32'h100, 32'h1234, 16'hFFFC));
    tick(); id_valid = 1'b0;
    @(negedge clk);
    chk("sw_store", ex_store_data, 32'h5555);
    chk("sw_b", alu_b, 32'hFFFFFFFC);
    chk("sw_a", alu_a, 32'h100);
    chk("sw_memwr", 32'(ex_mem_wr), 32'd1);
    chk("sw_wr", 32'(ex_wr_en), 32'd0);

    // sll puts rt on operand a
    #1;
    mwb_wr_en = 1'b0;
    drive(mk(6'h00, 6'h00, 5'd1, 5'd2, 5'd3, 32'd7, 32'h40000001, 16'h07C0));
    tick(); id_valid = 1'b0;
    @(negedge clk);
    chk("sll_a", alu_a, 32'h40000001);
    chk("sll_sel", 32'(alu_sel), 32'd5);

    // slti sign-extends, andi zero-extends
    #1;
    drive(mk(6'h0A, 6'h00, 5'd1, 5'd2, 5'd0, 32'd7, 32'd0, 16'h8000));
    tick();
    @(negedge clk);
    chk("slti_b", alu_b, 32'hFFFF8000);
    chk("slti_sel", 32'(alu_sel), 32'd4);
    #1;
    drive(mk(6'h0C, 6'h00, 5'd1, 5'd2, 5'd0, 32'd7, 32'd0, 16'h8000));
    tick(); id_valid = 1'b0;
    @(negedge clk);
    chk("andi_b", alu_b, 32'h00008000);
    chk("andi_sel", 32'(alu_sel), 32'd2);

    // back-to-back stream, checked by the model each cycle
    tbl[0] = mk(6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 32'd3, 32'd3, 16'h0010);
    tbl[1] = mk(6'h05, 6'h00, 5'd4, 5'd5, 5'd0, 32'd3, 32'd9, 16'h0020);
    tbl[2] = mk(6'h00, 6'h2A, 5'd6, 5'd7, 5'd8, 32'hFFFFFFFF, 32'd1, 16'h0000);
    tbl[3] = mk(6'h00, 6'h25, 5'd9, 5'd10, 5'd11, 32'hF0F0, 32'h0F0F, 16'h0000);
    tbl[4] = mk(6'h23, 6'h00, 5'd12, 5'd13, 5'd0, 32'h1000, 32'd0, 16'h8004);
    tbl[5] = mk(6'h00, 6'h21, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'h0000);
    #1;
    exm_wr_en = 1'b1; exm_wr_addr = 5'd7; exm_wr_data = 32'h77;
    foreach (tbl[k]) begin
      drive(tbl[k]);
      tick();
    end
    id_valid = 1'b0; exm_wr_en = 1'b0;
    repeat (2) tick();

    // asynchronous reset while an instruction is held
    drive(mk(6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 32'd5, 32'd0, 16'h0003));
    tick(); id_valid = 1'b0; ex_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ex_valid), 32'd0);
    chk("arst_sel", 32'(alu_sel), 32'd1);
    chk("arst_a", alu_a, 32'd0);
    tick(); rst_n = 1'b1; ex_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_valid", 32'(ex_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
